ascon_decrypt_top: RTL and testbench

Ascon-128 authenticated-decryption engine, the receive-side counterpart of the encryption top. It takes key, nonce, one pre-padded associated-data block and the expected tag at start. It then accepts a stream of full 64-bit ciphertext blocks, returns one plaintext block per ciphertext block, and finally recomputes the tag and flags authentication pass or fail. The permutation is self-contained, at one round per clock, using a 320-bit state register and a double-init round counter.

---
 rtl/ascon_decrypt_top.sv | 227 ++++++++++++++++++++++
 tb/tb_ascon_decrypt_top.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_decrypt_top.sv
// Ascon-128 authenticated decryption: one associated-data block, a stream of full 64-bit
// ciphertext blocks, tag recomputation and comparison. The permutation runs one round per clock.
module ascon_decrypt_top (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [63:0]  ad_i,
  input  logic [127:0] tag_i,
  input  logic         data_valid_i,
  input  logic         data_last_i,
  input  logic [63:0]  data_i,
  output logic         ready_o,
  output logic [63:0]  plain_o,
  output logic         plain_valid_o,
  output logic [127:0] tag_o,
  output logic         auth_ok_o,
  output logic         end_o,
  output logic         busy_o,
  output logic [2:0]   dbg_state_o
);

  // Handshake: a ciphertext block is consumed on a rising edge where ready_o and
  // data_valid_i are both high; data_valid_i while ready_o is low is simply ignored.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_AD    = 3'd2,
    S_WAIT  = 3'd3,
    S_DATA  = 3'd4,
    S_FINAL = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [63:0] IV  = 64'h80400C0600000000;
  localparam logic [63:0] PAD = 64'h8000000000000000;

  state_t r_state;
  state_t w_next;

  logic [63:0]  r_x0, r_x1, r_x2, r_x3, r_x4;
  logic [3:0]   r_cnt;
  logic [127:0] r_key;
  logic [63:0]  r_ad;
  logic [127:0] r_tag_exp;
  logic         r_last;
  logic [63:0]  r_plain;
  logic         r_plain_valid;
  logic [127:0] r_tag;
  logic         r_auth;

  logic         w_last_rnd;
  logic [127:0] w_tag_calc;
  logic [63:0]  w_a0, w_a1, w_a2, w_a3, w_a4;
  logic [63:0]  w_b2;
  logic [63:0]  w_c0, w_c1, w_c2, w_c3, w_c4;
  logic [63:0]  w_d0, w_d1, w_d2, w_d3, w_d4;
  logic [63:0]  w_e0, w_e1, w_e2, w_e3, w_e4;
  logic [63:0]  w_n0, w_n1, w_n2, w_n3, w_n4;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  assign w_last_rnd = (r_cnt == 4'd11);
  assign w_tag_calc = {r_x3, r_x4} ^ r_key;

  always_comb begin
    w_a0 = r_x0;
    w_a1 = r_x1;
    w_a2 = r_x2;
    w_a3 = r_x3;
    w_a4 = r_x4;
    if (r_state == S_AD && r_cnt == 4'd6) begin
      w_a0 = r_x0 ^ r_ad;
    end
    // The padding-only block and the finalisation key are absorbed into the first FINAL round.
    if (r_state == S_FINAL && r_cnt == 4'd0) begin
      w_a0 = r_x0 ^ PAD;
      w_a1 = r_x1 ^ r_key[127:64];
      w_a2 = r_x2 ^ r_key[63:0];
    end
    // Round constant is {~i, i} for round index i, so p6 simply starts the counter at 6.
    w_b2 = w_a2 ^ {56'd0, ~r_cnt, r_cnt};

    w_c0 = w_a0 ^ w_a4;
    w_c1 = w_a1;
    w_c2 = w_b2 ^ w_a1;
    w_c3 = w_a3;
    w_c4 = w_a4 ^ w_a3;

    w_d0 = w_c0 ^ (~w_c1 & w_c2);
    w_d1 = w_c1 ^ (~w_c2 & w_c3);
    w_d2 = w_c2 ^ (~w_c3 & w_c4);
    w_d3 = w_c3 ^ (~w_c4 & w_c0);
    w_d4 = w_c4 ^ (~w_c0 & w_c1);

    w_e0 = w_d0 ^ w_d4;
    w_e1 = w_d1 ^ w_d0;
    w_e2 = ~w_d2;
    w_e3 = w_d3 ^ w_d2;
    w_e4 = w_d4;

    w_n0 = w_e0 ^ ror64(w_e0, 19) ^ ror64(w_e0, 28);
    w_n1 = w_e1 ^ ror64(w_e1, 61) ^ ror64(w_e1, 39);
    w_n2 = w_e2 ^ ror64(w_e2, 1)  ^ ror64(w_e2, 6);
    w_n3 = w_e3 ^ ror64(w_e3, 10) ^ ror64(w_e3, 17);
    w_n4 = w_e4 ^ ror64(w_e4, 7)  ^ ror64(w_e4, 41);

    if (r_state == S_INIT && w_last_rnd) begin
      w_n3 = w_n3 ^ r_key[127:64];
      w_n4 = w_n4 ^ r_key[63:0];
    end
    if (r_state == S_AD && w_last_rnd) begin
      w_n4 = w_n4 ^ 64'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i)      w_next = S_INIT;
      S_INIT:  if (w_last_rnd)   w_next = S_AD;
      S_AD:    if (w_last_rnd)   w_next = S_WAIT;
      S_WAIT:  if (data_valid_i) w_next = S_DATA;
      S_DATA:  if (w_last_rnd)   w_next = r_last ? S_FINAL : S_WAIT;
      S_FINAL: if (r_cnt == 4'd12) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_x0          <= '0;
      r_x1          <= '0;
      r_x2          <= '0;
      r_x3          <= '0;
      r_x4          <= '0;
      r_cnt         <= '0;
      r_key         <= '0;
      r_ad          <= '0;
      r_tag_exp     <= '0;
      r_last        <= 1'b0;
      r_plain       <= '0;
      r_plain_valid <= 1'b0;
      r_tag         <= '0;
      r_auth        <= 1'b0;
    end else begin
      r_plain_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_x0      <= IV;
            r_x1      <= key_i[127:64];
            r_x2      <= key_i[63:0];
            r_x3      <= nonce_i[127:64];
            r_x4      <= nonce_i[63:0];
            r_key     <= key_i;
            r_ad      <= ad_i;
            r_tag_exp <= tag_i;
            r_tag     <= '0;
            r_auth    <= 1'b0;
            r_cnt     <= 4'd0;
          end
        end
        S_INIT, S_AD, S_DATA: begin
          r_x0 <= w_n0;
          r_x1 <= w_n1;
          r_x2 <= w_n2;
          r_x3 <= w_n3;
          r_x4 <= w_n4;
          if (w_last_rnd) begin
            r_cnt <= (r_state == S_INIT) ? 4'd6 : 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WAIT: begin
          if (data_valid_i) begin
            r_plain       <= r_x0 ^ data_i;
            r_plain_valid <= 1'b1;
            r_x0          <= data_i;
            r_last        <= data_last_i;
            r_cnt         <= 4'd6;
          end
        end
        S_FINAL: begin
          // Count 12 is a settle cycle: the tag is registered straight from the finished state.
          if (r_cnt == 4'd12) begin
            r_tag  <= w_tag_calc;
            r_auth <= (w_tag_calc == r_tag_exp);
          end else begin
            r_x0  <= w_n0;
            r_x1  <= w_n1;
            r_x2  <= w_n2;
            r_x3  <= w_n3;
            r_x4  <= w_n4;
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready_o       = (r_state == S_WAIT);
  assign busy_o        = (r_state != S_IDLE);
  assign end_o         = (r_state == S_DONE);
  assign plain_o       = r_plain;
  assign plain_valid_o = r_plain_valid;
  assign tag_o         = r_tag;
  assign auth_ok_o     = r_auth;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_ascon_decrypt_top.sv
// Bench for ascon_decrypt_top: a table-based Ascon-128 encryption model produces ciphertext
// and tags; the DUT must recover the plaintext, tag and authentication flag.
module tb_ascon_decrypt_top;

  logic         clock_i;
  logic         resetb_i;
  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] nonce_i;
  logic [63:0]  ad_i;
  logic [127:0] tag_i;
  logic         data_valid_i;
  logic         data_last_i;
  logic [63:0]  data_i;
  logic         ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic [127:0] tag_o;
  logic         auth_ok_o;
  logic         end_o;
  logic         busy_o;
  logic [2:0]   dbg_state_o;

  ascon_decrypt_top dut (
    .clock_i       (clock_i),
    .resetb_i      (resetb_i),
    .start_i       (start_i),
    .key_i         (key_i),
    .nonce_i       (nonce_i),
    .ad_i          (ad_i),
    .tag_i         (tag_i),
    .data_valid_i  (data_valid_i),
    .data_last_i   (data_last_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .plain_o       (plain_o),
    .plain_valid_o (plain_valid_o),
    .tag_o         (tag_o),
    .auth_ok_o     (auth_ok_o),
    .end_o         (end_o),
    .busy_o        (busy_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int errors = 0;
  int checks = 0;
  int pv_count = 0;
  logic [63:0] exp_q[$];

  always @(negedge clock_i) begin
    if (plain_valid_o) pv_count <= pv_count + 1;
  end

  localparam logic [63:0] M_IV  = 64'h80400C0600000000;
  localparam logic [63:0] M_PAD = 64'h8000000000000000;

  typedef struct {
    logic [127:0] key;
    logic [127:0] nonce;
    logic [63:0]  ad;
    logic [255:0] pt;
    int           nblk;
    logic         flip;
    logic         bad_tag;
    logic         exp_auth;
  } vec_t;

  vec_t vecs[5];

  // ---------------- reference model ----------------
  function automatic logic [4:0] m_sbox(input logic [4:0] v);
    case (v)
      5'h00: return 5'h04;  5'h01: return 5'h0b;  5'h02: return 5'h1f;  5'h03: return 5'h14;
      5'h04: return 5'h1a;  5'h05: return 5'h15;  5'h06: return 5'h09;  5'h07: return 5'h02;
      5'h08: return 5'h1b;  5'h09: return 5'h05;  5'h0a: return 5'h08;  5'h0b: return 5'h12;
      5'h0c: return 5'h1d;  5'h0d: return 5'h03;  5'h0e: return 5'h06;  5'h0f: return 5'h1c;
      5'h10: return 5'h1e;  5'h11: return 5'h13;  5'h12: return 5'h07;  5'h13: return 5'h0e;
      5'h14: return 5'h00;  5'h15: return 5'h0d;  5'h16: return 5'h11;  5'h17: return 5'h18;
      5'h18: return 5'h10;  5'h19: return 5'h0c;  5'h1a: return 5'h01;  5'h1b: return 5'h19;
      5'h1c: return 5'h16;  5'h1d: return 5'h0a;  5'h1e: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] m_rotr(input logic [63:0] v, input int n);
    logic [63:0] r;
    for (int j = 0; j < 64; j++) r[j] = v[(j + n) % 64];
    return r;
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input logic [7:0] rc);
    logic [63:0] x [5];
    logic [4:0]  o;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2][7:0] = x[2][7:0] ^ rc;
    for (int b = 0; b < 64; b++) begin
      o = m_sbox({x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]});
      x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
    end
    x[0] = x[0] ^ m_rotr(x[0], 19) ^ m_rotr(x[0], 28);
    x[1] = x[1] ^ m_rotr(x[1], 61) ^ m_rotr(x[1], 39);
    x[2] = x[2] ^ m_rotr(x[2], 1)  ^ m_rotr(x[2], 6);
    x[3] = x[3] ^ m_rotr(x[3], 10) ^ m_rotr(x[3], 17);
    x[4] = x[4] ^ m_rotr(x[4], 7)  ^ m_rotr(x[4], 41);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int nr);
    logic [319:0] t;
    t = s;
    for (int r = 12 - nr; r < 12; r++) t = m_round(t, 8'(240 - 15*r));
    return t;
  endfunction

  task automatic m_enc(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad,
                       input logic [255:0] pt, input int nb,
                       output logic [255:0] ct, output logic [127:0] tag);
    logic [319:0] s;
    logic [63:0]  c;
    ct = '0;
    s = m_perm({M_IV, k, n}, 12);
    s[127:0] = s[127:0] ^ k;
    s[319:256] = s[319:256] ^ ad;
    s = m_perm(s, 6);
    s[0] = ~s[0];
    for (int i = 0; i < nb; i++) begin
      c = s[319:256] ^ pt[255 - 64*i -: 64];
      ct[255 - 64*i -: 64] = c;
      s[319:256] = c;
      s = m_perm(s, 6);
    end
    s[319:256] = s[319:256] ^ M_PAD;
    s[255:128] = s[255:128] ^ k;
    s = m_perm(s, 12);
    tag = s[127:0] ^ k;
  endtask

  function automatic vec_t mk(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad,
                              input logic [255:0] pt, input int nb, input logic flip,
                              input logic bad, input logic ok);
    vec_t v;
    v.key = k; v.nonce = n; v.ad = ad; v.pt = pt; v.nblk = nb;
    v.flip = flip; v.bad_tag = bad; v.exp_auth = ok;
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [127:0] act, input logic [127:0] bad);
    checks++;
    if (act === bad) begin
      errors++;
      $display("FAIL %s: got %h which must differ from %h", name, act, bad);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!ready_o && n < 40) begin
      @(negedge clock_i);
      n++;
    end
    ok = ready_o;
  endtask

  task automatic wait_end(output bit ok);
    int n;
    n = 0;
    while (!end_o && n < 60) begin
      @(negedge clock_i);
      n++;
    end
    ok = end_o;
  endtask

  // ---------------- driver ----------------
  logic [127:0] last_tag;

  task automatic run_vec(input vec_t v, input bit abuse);
    logic [255:0] ptx, ct;
    logic [127:0] tag_m, tag_x;
    bit ok;
    int pv0;
    m_enc(v.key, v.nonce, v.ad, v.pt, v.nblk, ct, tag_m);
    ptx = v.pt;
    tag_x = tag_m;
    if (v.flip) begin
      ptx[128] = ~ptx[128];
      m_enc(v.key, v.nonce, v.ad, ptx, v.nblk, ct, tag_x);
    end
    for (int i = 0; i < v.nblk; i++) exp_q.push_back(ptx[255 - 64*i -: 64]);
    pv0 = pv_count;
    key_i = v.key; nonce_i = v.nonce; ad_i = v.ad;
    tag_i = v.bad_tag ? (tag_m ^ 128'h1) : tag_m;
    start_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    start_i = 1'b0;
    chk("start_busy", 128'(busy_o), 128'(1));
    chk("start_tag_clear", tag_o, 128'(0));
    chk("start_auth_clear", 128'(auth_ok_o), 128'(0));
    if (abuse) begin
      start_i = 1'b1; key_i = ~v.key; nonce_i = ~v.nonce;
      @(negedge clock_i);
      start_i = 1'b0;
    end
    for (int b = 0; b < v.nblk; b++) begin
      wait_ready(ok);
      if (!ok) begin
        timeout("ready_wait");
        return;
      end
      data_valid_i = 1'b1;
      data_i = ct[255 - 64*b -: 64];
      data_last_i = (b == v.nblk - 1);
      @(posedge clock_i);
      @(negedge clock_i);
      data_valid_i = 1'b0;
      chk("plain_valid", 128'(plain_valid_o), 128'(1));
      chk("plain_data", 128'(plain_o), 128'(exp_q.pop_front()));
      if (abuse) begin
        data_valid_i = 1'b1; data_i = ~data_i; start_i = 1'b1;
        @(negedge clock_i);
        data_valid_i = 1'b0; start_i = 1'b0;
        chk("abuse_no_plain", 128'(plain_valid_o), 128'(0));
      end
    end
    wait_end(ok);
    if (!ok) begin
      timeout("end_wait");
      return;
    end
    chk("tag_out", tag_o, tag_x);
    chk("auth_ok", 128'(auth_ok_o), 128'(v.exp_auth));
    if (v.flip) chk_ne("tamper_tag_differs", tag_o, tag_m);
    chk("plain_count", 128'(pv_count - pv0), 128'(v.nblk));
    last_tag = tag_x;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [255:0] ct1;
    logic [127:0] tag1;
    bit ok;
    int k;
    resetb_i = 1'b0; start_i = 1'b0; key_i = '0; nonce_i = '0; ad_i = '0; tag_i = '0;
    data_valid_i = 1'b0; data_last_i = 1'b0; data_i = '0;

    vecs[0] = mk(128'h000102030405060708090A0B0C0D0E0F, 128'h000102030405060708090A0B0C0D0E0F,
                 64'h4120746F20428000, {64'h5244562061752054, 64'h6927626172206365, 128'd0},
                 2, 1'b0, 1'b0, 1'b1);
    vecs[1] = mk(128'h000102030405060708090A0B0C0D0E0F, 128'h000102030405060708090A0B0C0D0E0F,
                 64'h4120746F20428000, {64'h5244562061752054, 64'h6927626172206365, 128'd0},
                 2, 1'b1, 1'b0, 1'b0);
    vecs[2] = mk(128'h000102030405060708090A0B0C0D0E0F, 128'h0F0E0D0C0B0A09080706050403020100,
                 64'h4120746F20428000, {64'hDEADBEEF01234567, 192'd0}, 1, 1'b0, 1'b0, 1'b1);
    vecs[3] = mk(128'h0123456789ABCDEFFEDCBA9876543210, 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C,
                 64'h8000000000000000,
                 {64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0F1E2D3C4B5A6978, 64'd0},
                 3, 1'b0, 1'b0, 1'b1);
    vecs[4] = mk(128'h000102030405060708090A0B0C0D0E0F, 128'h000102030405060708090A0B0C0D0E0F,
                 64'h4120746F20428000, {64'h5244562061752054, 64'h6927626172206365, 128'd0},
                 2, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clock_i);
    chk("rst_ready", 128'(ready_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_end", 128'(end_o), 128'(0));
    chk("rst_plain_valid", 128'(plain_valid_o), 128'(0));
    chk("rst_plain", 128'(plain_o), 128'(0));
    chk("rst_tag", tag_o, 128'(0));
    chk("rst_auth", 128'(auth_ok_o), 128'(0));
    chk("rst_state", 128'(dbg_state_o), 128'(0));
    resetb_i = 1'b1;
    @(negedge clock_i);

    // Table: each vector is followed by a start during the end_o cycle, which must be ignored.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], (i == 0) || (i == 3));
      start_i = 1'b1;
      nonce_i = ~nonce_i;
      @(posedge clock_i);
      @(negedge clock_i);
      start_i = 1'b0;
      chk("start_in_done_ignored", 128'(busy_o), 128'(0));
      chk("tag_held", tag_o, last_tag);
    end

    // Latency: single block with data_valid_i held high from the start edge onward.
    m_enc(vecs[2].key, vecs[2].nonce, vecs[2].ad, vecs[2].pt, 1, ct1, tag1);
    key_i = vecs[2].key; nonce_i = vecs[2].nonce; ad_i = vecs[2].ad; tag_i = tag1;
    data_valid_i = 1'b1; data_last_i = 1'b1; data_i = ct1[255:192];
    start_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    start_i = 1'b0;
    k = 0;
    while (!ready_o && k < 40) begin
      @(negedge clock_i);
      k++;
    end
    chk("lat_ready_edge", 128'(k + 1), 128'(19));
    @(posedge clock_i);
    @(negedge clock_i);
    chk("lat_plain", 128'(plain_o), 128'(vecs[2].pt[255:192]));
    k = 0;
    while (!end_o && k < 60) begin
      @(negedge clock_i);
      k++;
    end
    chk("lat_end_edge", 128'(k + 1), 128'(20));
    chk("lat_tag", tag_o, tag1);
    chk("lat_auth", 128'(auth_ok_o), 128'(1));
    data_valid_i = 1'b0;
    @(negedge clock_i);

    // Reset in the middle of DATA aborts the operation.
    m_enc(vecs[0].key, vecs[0].nonce, vecs[0].ad, vecs[0].pt, 2, ct1, tag1);
    key_i = vecs[0].key; nonce_i = vecs[0].nonce; ad_i = vecs[0].ad; tag_i = tag1;
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    wait_ready(ok);
    if (!ok) timeout("rst_test_ready");
    data_valid_i = 1'b1; data_last_i = 1'b0; data_i = ct1[255:192];
    @(negedge clock_i);
    data_valid_i = 1'b0;
    @(negedge clock_i);
    resetb_i = 1'b0;
    #1;
    chk("abort_state", 128'(dbg_state_o), 128'(0));
    chk("abort_busy", 128'(busy_o), 128'(0));
    chk("abort_ready", 128'(ready_o), 128'(0));
    chk("abort_end", 128'(end_o), 128'(0));
    chk("abort_plain", 128'(plain_o), 128'(0));
    chk("abort_plain_valid", 128'(plain_valid_o), 128'(0));
    chk("abort_tag", tag_o, 128'(0));
    chk("abort_auth", 128'(auth_ok_o), 128'(0));
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(negedge clock_i);
    run_vec(vecs[0], 1'b0);

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
